// File: rtl/fetch_ctrl.sv
// Fetch/branch sequencer in front of the PC: fetches, latches and dispatches
// instructions, and produces the one-cycle PC update with its branch select/displacement.
module fetch_ctrl #(
  parameter int unsigned IW = 16,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] mem_rdata,
  input  logic [4:0]    flags,
  input  logic          exec_done,
  output logic          mem_ren,
  output logic [IW-1:0] instr,
  output logic          exec_start,
  output logic          pc_enable,
  output logic          branch_select,
  output logic [DW-1:0] disp
);

  localparam int unsigned OPW      = 4;
  localparam logic [OPW-1:0] OP_BCOND = 4'hC;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_BRANCH,
    S_UPDATE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            mem_ren_d;
  logic            exec_start_d;
  logic            pc_enable_d;
  logic            branch_select_d;
  logic [IW-1:0]   instr_d;
  logic [DW-1:0]   disp_d;
  logic            taken;
  logic [OPW-1:0]  cond;
  logic            f_n, f_l, f_f, f_z, f_c;

  assign cond = instr[11:8];
  assign {f_n, f_l, f_f, f_z, f_c} = flags;

  // Branch condition evaluated against the flags seen during BRANCH; the result is registered.
  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0: taken = f_z;
      4'h1: taken = ~f_z;
      4'h2: taken = f_c;
      4'h3: taken = ~f_c;
      4'h4: taken = f_l;
      4'h5: taken = ~f_l;
      4'h6: taken = f_n;
      4'h7: taken = ~f_n;
      4'h8: taken = f_f;
      4'h9: taken = ~f_f;
      4'hA: taken = ~f_l & ~f_z;
      4'hB: taken = f_l | f_z;
      4'hC: taken = ~f_n & ~f_z;
      4'hD: taken = f_n | f_z;
      4'hE: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and next-output logic; outputs take effect on the edge leaving the state.
  always_comb begin
    state_d         = state_q;
    mem_ren_d       = 1'b0;
    exec_start_d    = 1'b0;
    pc_enable_d     = 1'b0;
    branch_select_d = branch_select;
    disp_d          = disp;
    instr_d         = instr;
    case (state_q)
      S_FETCH: begin
        mem_ren_d = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        instr_d = mem_rdata;
        if (mem_rdata[IW-1 -: OPW] == OP_BCOND) begin
          state_d = S_BRANCH;
        end else begin
          exec_start_d = 1'b1;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        // A done pulse coincident with exec_start belongs to no instruction yet.
        if (exec_done && !exec_start) begin
          branch_select_d = 1'b0;
          state_d         = S_UPDATE;
        end
      end
      S_BRANCH: begin
        branch_select_d = taken;
        disp_d          = instr[DW-1:0];
        state_d         = S_UPDATE;
      end
      S_UPDATE: begin
        pc_enable_d = 1'b1;
        state_d     = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      mem_ren       <= 1'b0;
      exec_start    <= 1'b0;
      pc_enable     <= 1'b0;
      branch_select <= 1'b0;
      disp          <= '0;
      instr         <= '0;
    end else begin
      state_q       <= state_d;
      mem_ren       <= mem_ren_d;
      exec_start    <= exec_start_d;
      pc_enable     <= pc_enable_d;
      branch_select <= branch_select_d;
      disp          <= disp_d;
      instr         <= instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a one-cycle-latency instruction memory model
// and per-scenario tasks with hand-computed expectations.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mem_rdata;
  logic [4:0]  flags = 5'b00000;
  logic        exec_done = 1'b0;
  logic        mem_ren;
  logic [15:0] instr;
  logic        exec_start;
  logic        pc_enable;
  logic        branch_select;
  logic [7:0]  disp;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] cur_word = 16'h0000;

  fetch_ctrl #(.IW(16), .DW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_rdata     (mem_rdata),
    .flags         (flags),
    .exec_done     (exec_done),
    .mem_ren       (mem_ren),
    .instr         (instr),
    .exec_start    (exec_start),
    .pc_enable     (pc_enable),
    .branch_select (branch_select),
    .disp          (disp)
  );

  initial forever #5 clk = ~clk;

  // Synchronous memory: data valid only in the cycle after a read strobe.
  always @(posedge clk) mem_rdata <= mem_ren ? cur_word : 16'hEEEE;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    exec_done = 1'b0;
    cur_word = 16'h0123;
    repeat (3) tick();
    vectors++;
    if ({mem_ren, exec_start, pc_enable, branch_select} !== 4'b0000 || instr !== 16'h0000 || disp !== 8'h00) begin
      $display("FAIL rst_values got ren/st/pe/bs=%b instr=%h disp=%h want 0000/0000/00",
               {mem_ren, exec_start, pc_enable, branch_select}, instr, disp);
      miscompares++;
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({mem_ren, exec_start, pc_enable} !== 3'b100) begin
      $display("FAIL rst_first_fetch got ren/st/pe=%b want 100", {mem_ren, exec_start, pc_enable});
      miscompares++;
    end
  endtask

  // Entry/exit: negedge of the cycle where mem_ren is high.
  task automatic run_exec(input string name, input logic [15:0] word, input int n_wait, input logic stray);
    int extra;
    cur_word = word;
    exec_done = stray;
    tick();
    vectors++;
    if ({mem_ren, exec_start, pc_enable} !== 3'b000) begin
      $display("FAIL %s_decode got ren/st/pe=%b want 000", name, {mem_ren, exec_start, pc_enable});
      miscompares++;
    end
    tick();
    vectors++;
    if (exec_start !== 1'b1 || instr !== word || pc_enable !== 1'b0) begin
      $display("FAIL %s_start got st=%b instr=%h pe=%b want 1 %h 0", name, exec_start, instr, pc_enable, word);
      miscompares++;
    end
    tick();
    exec_done = 1'b0;
    vectors++;
    if ({exec_start, pc_enable} !== 2'b00) begin
      $display("FAIL %s_start_pulse got st/pe=%b want 00", name, {exec_start, pc_enable});
      miscompares++;
    end
    extra = 0;
    for (int i = 0; i < n_wait; i++) begin
      tick();
      if (pc_enable !== 1'b0) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      $display("FAIL %s_wait_no_pe got %0d pulses want 0", name, extra);
      miscompares++;
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    vectors++;
    if (pc_enable !== 1'b0) begin
      $display("FAIL %s_update_early got pe=%b want 0", name, pc_enable);
      miscompares++;
    end
    tick();
    vectors++;
    if ({pc_enable, branch_select} !== 2'b10) begin
      $display("FAIL %s_pc_update got pe/bs=%b want 10", name, {pc_enable, branch_select});
      miscompares++;
    end
    exec_done = stray;
    tick();
    exec_done = 1'b0;
    vectors++;
    if ({mem_ren, pc_enable} !== 2'b10) begin
      $display("FAIL %s_refetch got ren/pe=%b want 10", name, {mem_ren, pc_enable});
      miscompares++;
    end
  endtask

  task automatic run_branch(input string name, input logic [15:0] word, input logic [4:0] fl, input logic exp_sel);
    logic [7:0] exp_disp;
    exp_disp = word[7:0];
    cur_word = word;
    flags = fl;
    tick();
    vectors++;
    if ({mem_ren, exec_start, pc_enable} !== 3'b000) begin
      $display("FAIL %s_decode got ren/st/pe=%b want 000", name, {mem_ren, exec_start, pc_enable});
      miscompares++;
    end
    tick();
    vectors++;
    if (instr !== word || {exec_start, pc_enable} !== 2'b00) begin
      $display("FAIL %s_latch got instr=%h st/pe=%b want %h 00", name, instr, {exec_start, pc_enable}, word);
      miscompares++;
    end
    tick();
    vectors++;
    if ({pc_enable, branch_select} !== {1'b0, exp_sel} || disp !== exp_disp) begin
      $display("FAIL %s_eval got pe/bs=%b disp=%h want %b %h", name, {pc_enable, branch_select}, disp,
               {1'b0, exp_sel}, exp_disp);
      miscompares++;
    end
    tick();
    vectors++;
    if ({pc_enable, branch_select} !== {1'b1, exp_sel} || disp !== exp_disp) begin
      $display("FAIL %s_pc_update got pe/bs=%b disp=%h want %b %h", name, {pc_enable, branch_select}, disp,
               {1'b1, exp_sel}, exp_disp);
      miscompares++;
    end
    tick();
    vectors++;
    if ({mem_ren, pc_enable, branch_select} !== {2'b10, exp_sel} || disp !== exp_disp) begin
      $display("FAIL %s_hold got ren/pe/bs=%b disp=%h want %b %h", name, {mem_ren, pc_enable, branch_select},
               disp, {2'b10, exp_sel}, exp_disp);
      miscompares++;
    end
  endtask

  task automatic test_nonbranch();
    run_exec("nb0123", 16'h0123, 1, 1'b1);
  endtask

  task automatic test_branch_taken();
    run_branch("beq_taken", 16'hC005, 5'b00010, 1'b1);
  endtask

  task automatic test_branch_not_taken();
    run_branch("bne_not_taken", 16'hC1FB, 5'b00010, 1'b0);
  endtask

  task automatic test_cond_sweep();
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
    exp_lo = 16'h56AA;
    exp_hi = 16'h6955;
    for (int c = 0; c < 16; c++) begin
      run_branch($sformatf("sweep0_c%0h", c), {4'hC, 4'(c), 8'h80}, 5'b00000, exp_lo[c]);
      run_branch($sformatf("sweep1_c%0h", c), {4'hC, 4'(c), 8'h80}, 5'b11111, exp_hi[c]);
    end
  endtask

  task automatic test_cond_mixed();
    logic [4:0] fl  [12] = '{5'b01000, 5'b01000, 5'b10000, 5'b10000, 5'b10000, 5'b00100,
                             5'b00100, 5'b00001, 5'b00010, 5'b00010, 5'b01000, 5'b00001};
    logic [3:0] cd  [12] = '{4'h4, 4'h6, 4'h6, 4'hC, 4'hA, 4'h8, 4'h0, 4'h2, 4'hB, 4'hC, 4'hD, 4'h3};
    logic       exp [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++)
      run_branch($sformatf("mixed_%0d", i), {4'hC, cd[i], 8'h7F}, fl[i], exp[i]);
  endtask

  task automatic test_exec_hang();
    run_exec("exec_hang", 16'h4321, 50, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_exec("b2b_a", 16'h0ABC, 0, 1'b0);
    run_branch("b2b_bmax", 16'hCE7F, 5'b00000, 1'b1);
    run_exec("b2b_c", 16'hB001, 3, 1'b1);
    run_branch("b2b_bmin", 16'hCE80, 5'b00000, 1'b1);
    run_branch("b2b_bpos", 16'hC07F, 5'b00010, 1'b1);
  endtask

  task automatic test_reset_mid_exec();
    int pulses;
    cur_word = 16'h1234;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if ({mem_ren, exec_start, pc_enable, branch_select} !== 4'b0000 || instr !== 16'h0000 || disp !== 8'h00) begin
      $display("FAIL rst_exec_clear got ren/st/pe/bs=%b instr=%h disp=%h want 0000/0000/00",
               {mem_ren, exec_start, pc_enable, branch_select}, instr, disp);
      miscompares++;
    end
    pulses = 0;
    exec_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (pc_enable !== 1'b0) pulses++;
    end
    exec_done = 1'b0;
    reset = 1'b1;
    tick();
    if (pc_enable !== 1'b0) pulses++;
    vectors++;
    if (mem_ren !== 1'b1 || pulses !== 0) begin
      $display("FAIL rst_exec_restart got ren=%b pulses=%0d want 1 0", mem_ren, pulses);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_update();
    int pulses;
    cur_word = 16'hCE10;
    tick();
    tick();
    tick();
    vectors++;
    if ({pc_enable, branch_select} !== 2'b01 || disp !== 8'h10) begin
      $display("FAIL rst_upd_pre got pe/bs=%b disp=%h want 01 10", {pc_enable, branch_select}, disp);
      miscompares++;
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({mem_ren, exec_start, pc_enable, branch_select} !== 4'b0000 || instr !== 16'h0000 || disp !== 8'h00) begin
      $display("FAIL rst_upd_clear got ren/st/pe/bs=%b instr=%h disp=%h want 0000/0000/00",
               {mem_ren, exec_start, pc_enable, branch_select}, instr, disp);
      miscompares++;
    end
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (pc_enable !== 1'b0) pulses++;
    end
    reset = 1'b1;
    tick();
    if (pc_enable !== 1'b0) pulses++;
    vectors++;
    if (mem_ren !== 1'b1 || pulses !== 0) begin
      $display("FAIL rst_upd_restart got ren=%b pulses=%0d want 1 0", mem_ren, pulses);
      miscompares++;
    end
    run_branch("post_rst_bcc", 16'hC3AA, 5'b00001, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nonbranch();
    test_branch_taken();
    test_branch_not_taken();
    test_cond_sweep();
    test_cond_mixed();
    test_exec_hang();
    test_back_to_back();
    test_reset_mid_exec();
    test_back_to_back();
    test_reset_mid_update();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Multi-cycle fetch/branch controller directly upstream of the program counter.
- Sequences instruction fetch from the synchronous instruction memory and latches the instruction word.
- Hands non-branch instructions to the datapath and waits for completion.
- Drives the PC's update controls: pc_enable, branch_select, disp.
- Evaluates Bcond instructions against the processor status flags to choose sequential or PC-relative update.

Parameters:
- IW, 16, instruction word width.
- DW, 8, branch displacement width (instruction bits DW-1:0).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_rdata  in  IW  instruction memory read data; valid one cycle after mem_ren.
- flags  in  5  status flags {N,L,F,Z,C}; bit 4 = N, bit 0 = C.
- exec_done  in  1  datapath pulse: current instruction finished.
- mem_ren  out  1  instruction memory read strobe; the address is the PC output.
- instr  out  IW  instruction register.
- exec_start  out  1  one-cycle pulse: datapath may begin executing instr.
- pc_enable  out  1  one-cycle pulse: PC updates this edge.
- branch_select  out  1  1 = PC loads prev_addr + disp; 0 = PC loads prev_addr + 1.
- disp  out  DW  branch displacement, instr[DW-1:0], two's complement; the PC stage sign-extends it.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, instr=16'h0000, mem_ren=0, exec_start=0, pc_enable=0, branch_select=0, disp=0.
- The first FETCH after reset release asserts mem_ren on the next edge.
- All outputs are registered.
- States and transitions:
  - FETCH: mem_ren=1 for one cycle -> WAIT.
  - WAIT: memory latency cycle; mem_ren=0 -> DECODE.
  - DECODE: instr <= mem_rdata. If mem_rdata[15:12]==4'hC (Bcond) -> BRANCH; else exec_start=1 for one cycle -> EXEC.
  - EXEC: hold until exec_done=1 -> UPDATE with branch_select=0. exec_done is ignored in every other state.
  - BRANCH: evaluate cond=instr[11:8] against flags (registered copy sampled in this state) -> UPDATE with branch_select=taken, disp=instr[7:0].
  - UPDATE: pc_enable=1 for exactly one cycle; branch_select and disp stable during it -> FETCH.
- Condition table (taken when):
  - 0 EQ Z=1; 1 NE Z=0; 2 CS C=1; 3 CC C=0.
  - 4 HI L=1; 5 LS L=0; 6 GT N=1; 7 LE N=0.
  - 8 FS F=1; 9 FC F=0; A LO L=0&Z=0; B HS L=1|Z=1.
  - C LT N=0&Z=0; D GE N=1|Z=1; E UC always; F never.
- A not-taken branch is an ordinary PC+1 update (branch_select=0).
- Latency:
  - Non-branch: 4 cycles + exec wait (FETCH, WAIT, DECODE, EXEC≥1, UPDATE).
  - Branch: 5 cycles.
- exec_done arriving in the same cycle exec_start is asserted is not accepted; EXEC needs ≥1 cycle.
- branch_select and disp hold their values after UPDATE until the next UPDATE. pc_enable is 0 except in UPDATE.
- Reset mid-instruction: immediate return to reset values. No pc_enable pulse is emitted for the aborted instruction.
- disp=8'h80 (−128) and 8'h7F (+127) pass through unmodified. Wrap-around of the address is the PC's responsibility.

Test Plan:
- Reset held 3 cycles, released; mem_rdata=16'h0123 (non-branch) -> mem_ren pulse in cycle 1, exec_start pulse when instr=16'h0123; exec_done after 2 cycles -> single pc_enable pulse with branch_select=0.
- mem_rdata=16'hC005 (BEQ +5), flags Z=1 -> no exec_start; pc_enable pulse with branch_select=1, disp=8'h05, 5 cycles after mem_ren.
- mem_rdata=16'hC1FB (BNE −5), flags Z=1 -> pc_enable pulse with branch_select=0, disp=8'hFB.
- Sweep cond 0..F with instr low byte 8'h80 under flags 5'b00000 and 5'b11111 -> branch_select matches the condition table for all 32 cases; UC always 1, code F always 0.
- exec_done held 0 for 50 cycles in EXEC -> no pc_enable. Stray exec_done pulses during FETCH/WAIT -> ignored, no state change.
- reset asserted during EXEC and during UPDATE -> all outputs 0 same cycle, no pc_enable pulse; after release, fetch restarts cleanly with mem_ren.
